// File: rtl/sap_pkg.sv
// Shared types for the SAP core: opcodes, one-hot T-states and the decoded control word.
package sap_pkg;

  typedef enum logic [3:0] {
    OP_LDA = 4'h0,
    OP_ADD = 4'h1,
    OP_SUB = 4'h2,
    OP_STA = 4'h3,
    OP_LDI = 4'h4,
    OP_JMP = 4'h5,
    OP_JC  = 4'h6,
    OP_JZ  = 4'h7,
    OP_OUT = 4'hE,
    OP_HLT = 4'hF
  } opcode_t;

  typedef logic [5:0] tstate_t;

  localparam tstate_t T1 = 6'b000001;
  localparam tstate_t T2 = 6'b000010;
  localparam tstate_t T3 = 6'b000100;
  localparam tstate_t T4 = 6'b001000;
  localparam tstate_t T5 = 6'b010000;
  localparam tstate_t T6 = 6'b100000;

  typedef enum logic [1:0] {
    ASRC_MEM = 2'd0,
    ASRC_ALU = 2'd1,
    ASRC_IMM = 2'd2
  } asrc_t;

  // mar_opnd picks the operand over PC as MAR source; a_src steers the A load.
  typedef struct packed {
    logic  ld_mar;
    logic  mar_opnd;
    logic  inc_pc;
    logic  ld_pc;
    logic  ld_ir;
    logic  ld_a;
    asrc_t a_src;
    logic  ld_b;
    logic  ld_out;
    logic  alu_op;
    logic  we;
    logic  upd_flags;
    logic  hlt;
  } ctrl_t;

  function automatic tstate_t ring_next(input tstate_t t);
    return {t[4:0], t[5]};
  endfunction

endpackage

// File: rtl/sap_core_p_if.sv
// Memory bus between the SAP core and the board-level program/data memory.
interface sap_core_p_if #(
  parameter int DATA_W = 8,
  parameter int ADDR_W = 4
);
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_rdata;
  logic [DATA_W-1:0] mem_wdata;
  logic              mem_we;

  modport master (
    output mem_addr,
    output mem_wdata,
    output mem_we,
    input  mem_rdata
  );

  modport slave (
    input  mem_addr,
    input  mem_wdata,
    input  mem_we,
    output mem_rdata
  );
endinterface

// File: rtl/sap_alu.sv
// Combinational add/subtract unit; on subtract the carry output means "no borrow" (a >= b).
module sap_alu #(
  parameter int DATA_W = 8
) (
  input  logic [DATA_W-1:0] a,
  input  logic [DATA_W-1:0] b,
  input  logic              sub,
  output logic [DATA_W-1:0] result,
  output logic              c,
  output logic              z
);
  logic [DATA_W:0] sum;

  always_comb begin
    if (sub) sum = {1'b0, a} - {1'b0, b};
    else     sum = {1'b0, a} + {1'b0, b};
  end

  assign result = sum[DATA_W-1:0];
  assign c      = sub ? ~sum[DATA_W] : sum[DATA_W];
  assign z      = (sum[DATA_W-1:0] == '0);
endmodule

// File: rtl/sap_core_p.sv
// Six-state ring-sequenced SAP accumulator core: fetch in T1-T3, execute in T4-T6.
// Program/data memory sits outside on the bus interface; HLT freezes the ring at T4 until CLR.
module sap_core_p
  import sap_pkg::*;
#(
  parameter int DATA_W = 8,
  parameter int ADDR_W = 4
) (
  input  logic              clk,
  input  logic              CLR,
  input  logic              run,
  sap_core_p_if.master      bus,
  output logic [DATA_W-1:0] out_reg,
  output logic              out_valid,
  output logic              halted,
  output logic              flag_c,
  output logic              flag_z,
  output logic [5:0]        ring_count,
  output logic [ADDR_W-1:0] prog_counter,
  output logic [DATA_W-1:0] a_reg
);
  tstate_t           ring;
  logic [ADDR_W-1:0] pc;
  logic [ADDR_W-1:0] mar;
  logic [DATA_W-1:0] ir;
  logic [DATA_W-1:0] a;
  logic [DATA_W-1:0] b;
  opcode_t           opc;
  logic [ADDR_W-1:0] opnd;
  ctrl_t             ctrl;
  logic [DATA_W-1:0] alu_res;
  logic              alu_c;
  logic              alu_z;
  logic [DATA_W-1:0] a_next;
  logic              unused_ir;

  assign opc       = opcode_t'(ir[DATA_W-1 -: 4]);
  assign opnd      = ir[ADDR_W-1:0];
  assign unused_ir = ^ir;

  // Whole decode: (T-state, opcode, flags) -> control word; a halted core issues nothing.
  always_comb begin
    ctrl = '0;
    if (!halted) begin
      case (ring)
        T1: ctrl.ld_mar = run;
        T2: ctrl.inc_pc = 1'b1;
        T3: ctrl.ld_ir  = 1'b1;
        T4: begin
          case (opc)
            OP_LDA, OP_ADD, OP_SUB, OP_STA: begin
              ctrl.ld_mar   = 1'b1;
              ctrl.mar_opnd = 1'b1;
            end
            OP_LDI: begin
              ctrl.ld_a  = 1'b1;
              ctrl.a_src = ASRC_IMM;
            end
            OP_JMP:  ctrl.ld_pc  = 1'b1;
            OP_JC:   ctrl.ld_pc  = flag_c;
            OP_JZ:   ctrl.ld_pc  = flag_z;
            OP_OUT:  ctrl.ld_out = 1'b1;
            OP_HLT:  ctrl.hlt    = 1'b1;
            default: ;
          endcase
        end
        T5: begin
          case (opc)
            OP_LDA: begin
              ctrl.ld_a  = 1'b1;
              ctrl.a_src = ASRC_MEM;
            end
            OP_ADD, OP_SUB: ctrl.ld_b = 1'b1;
            OP_STA:         ctrl.we   = 1'b1;
            default: ;
          endcase
        end
        T6: begin
          if (opc == OP_ADD || opc == OP_SUB) begin
            ctrl.ld_a      = 1'b1;
            ctrl.a_src     = ASRC_ALU;
            ctrl.alu_op    = (opc == OP_SUB);
            ctrl.upd_flags = 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  sap_alu #(.DATA_W(DATA_W)) u_alu (
    .a      (a),
    .b      (b),
    .sub    (ctrl.alu_op),
    .result (alu_res),
    .c      (alu_c),
    .z      (alu_z)
  );

  always_comb begin
    case (ctrl.a_src)
      ASRC_ALU: a_next = alu_res;
      ASRC_IMM: a_next = {{(DATA_W-ADDR_W){1'b0}}, opnd};
      default:  a_next = bus.mem_rdata;
    endcase
  end

  // Ring stalls in T1 while run is low, and stays parked at T4 from the HLT edge onward.
  always_ff @(posedge clk or posedge CLR) begin
    if (CLR) begin
      ring <= T1;
    end else if (!(halted || ctrl.hlt || (ring == T1 && !run))) begin
      ring <= ring_next(ring);
    end
  end

  always_ff @(posedge clk or posedge CLR) begin
    if (CLR) begin
      pc        <= '0;
      mar       <= '0;
      ir        <= '0;
      a         <= '0;
      b         <= '0;
      out_reg   <= '0;
      out_valid <= 1'b0;
      halted    <= 1'b0;
      flag_c    <= 1'b0;
      flag_z    <= 1'b0;
    end else begin
      if (ctrl.ld_mar) mar <= ctrl.mar_opnd ? opnd : pc;
      if (ctrl.ld_pc)       pc <= opnd;
      else if (ctrl.inc_pc) pc <= pc + 1'b1;
      if (ctrl.ld_ir)  ir      <= bus.mem_rdata;
      if (ctrl.ld_b)   b       <= bus.mem_rdata;
      if (ctrl.ld_a)   a       <= a_next;
      if (ctrl.ld_out) out_reg <= a;
      out_valid <= ctrl.ld_out;
      if (ctrl.hlt)    halted  <= 1'b1;
      if (ctrl.upd_flags) begin
        flag_c <= alu_c;
        flag_z <= alu_z;
      end
    end
  end

  // The write strobe must vanish the instant CLR rises, before the ring flops settle.
  assign bus.mem_we    = ctrl.we & ~CLR;
  assign bus.mem_addr  = mar;
  assign bus.mem_wdata = a;

  assign ring_count   = ring;
  assign prog_counter = pc;
  assign a_reg        = a;
endmodule

// File: tb/tb_sap_core_p.sv
// Testbench for sap_core_p: an 8/4 core for table, sequence and random tests plus a 12/8 core.
module tb_sap_core_p;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic clr8, run8, clr12, run12;

  sap_core_p_if #(.DATA_W(8),  .ADDR_W(4)) bus8 ();
  sap_core_p_if #(.DATA_W(12), .ADDR_W(8)) bus12 ();

  logic [7:0]  mem8  [16];
  logic [11:0] mem12 [256];

  assign bus8.mem_rdata  = mem8[bus8.mem_addr];
  assign bus12.mem_rdata = mem12[bus12.mem_addr];

  logic [7:0]  outReg8, aReg8;
  logic        outValid8, halted8, flagC8, flagZ8;
  logic [5:0]  ring8;
  logic [3:0]  pc8;
  logic [11:0] outReg12, aReg12;
  logic        outValid12, halted12, flagC12, flagZ12;
  logic [5:0]  ring12;
  logic [7:0]  pc12;

  sap_core_p #(.DATA_W(8), .ADDR_W(4)) dut8 (
    .clk(clk), .CLR(clr8), .run(run8), .bus(bus8),
    .out_reg(outReg8), .out_valid(outValid8), .halted(halted8),
    .flag_c(flagC8), .flag_z(flagZ8), .ring_count(ring8),
    .prog_counter(pc8), .a_reg(aReg8)
  );

  sap_core_p #(.DATA_W(12), .ADDR_W(8)) dut12 (
    .clk(clk), .CLR(clr12), .run(run12), .bus(bus12),
    .out_reg(outReg12), .out_valid(outValid12), .halted(halted12),
    .flag_c(flagC12), .flag_z(flagZ12), .ring_count(ring12),
    .prog_counter(pc12), .a_reg(aReg12)
  );

  int checks = 0;
  int failures = 0;
  int cyc = 0;
  int weCount = 0;
  int weEdge = 0;
  logic [3:0] weAddr;
  logic [7:0] weData;

  // Reference ISA-level machine state
  logic [3:0] mPc;
  logic [7:0] mA, mOut;
  logic       mC, mZ, mHalt;
  logic [7:0] mMem [16];

  typedef struct {
    logic       sub;
    logic [7:0] x;
    logic [7:0] y;
    logic [7:0] expA;
    logic       expC;
    logic       expZ;
  } aluVec_t;
  aluVec_t vecs [8];

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // One clock: write-strobe state is captured before the edge, memory updated at the edge.
  task automatic tick();
    logic       we8s, we12s;
    logic [3:0] a8;
    logic [7:0] d8, a12;
    logic [11:0] d12;
    we8s = bus8.mem_we;   a8  = bus8.mem_addr;  d8  = bus8.mem_wdata;
    we12s = bus12.mem_we; a12 = bus12.mem_addr; d12 = bus12.mem_wdata;
    @(posedge clk);
    if (we8s) begin
      mem8[a8] = d8;
      weCount++;
      weAddr = a8;
      weData = d8;
      weEdge = cyc + 1;
    end
    if (we12s) mem12[a12] = d12;
    cyc++;
    #1;
  endtask

  task automatic tickN(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic clearMem8();
    for (int i = 0; i < 16; i++) mem8[i] = 8'h80;
  endtask

  // Pulse CLR on the 8-bit core and release it on a falling edge; next tick is posedge 1.
  task automatic applyStimulus8(input logic runLevel);
    clr8 = 1'b1;
    run8 = runLevel;
    @(negedge clk);
    @(negedge clk);
    clr8 = 1'b0;
    cyc = 0;
    weCount = 0;
    weEdge = 0;
    weAddr = '0;
    weData = '0;
  endtask

  task automatic modelStep();
    logic [7:0] w;
    logic [3:0] op, opd;
    int s;
    if (mHalt) return;
    w = mMem[mPc];
    op = w[7:4];
    opd = w[3:0];
    mPc = mPc + 4'd1;
    case (op)
      4'h0: mA = mMem[opd];
      4'h1: begin
        s = int'(mA) + int'(mMem[opd]);
        mC = (s > 255);
        mA = 8'(s);
        mZ = (mA == 8'd0);
      end
      4'h2: begin
        mC = (mA >= mMem[opd]);
        mA = mA - mMem[opd];
        mZ = (mA == 8'd0);
      end
      4'h3: mMem[opd] = mA;
      4'h4: mA = {4'h0, opd};
      4'h5: mPc = opd;
      4'h6: if (mC) mPc = opd;
      4'h7: if (mZ) mPc = opd;
      4'hE: mOut = mA;
      4'hF: mHalt = 1'b1;
      default: ;
    endcase
  endtask

  initial begin
    int ovCycle, ovCount, haltCycle, bad, n;
    logic [7:0] ovVal;
    logic [3:0] op;

    clr8 = 1'b0; clr12 = 1'b0; run8 = 1'b0; run12 = 1'b0;
    clearMem8();
    for (int i = 0; i < 256; i++) mem12[i] = '0;
    #1;
    clr8 = 1'b1; clr12 = 1'b1;
    @(negedge clk);

    // Reset state
    checkOutput("rst_ring", 32'(ring8), 32'h01);
    checkOutput("rst_pc_a_out", 32'({pc8, aReg8, outReg8}), 32'h0);
    checkOutput("rst_flags", 32'({flagC8, flagZ8, halted8, outValid8}), 32'h0);
    checkOutput("rst_bus", 32'({bus8.mem_we, bus8.mem_addr}), 32'h0);

    // Table-driven ALU vectors: LDA E; ADD/SUB F; HLT
    vecs[0] = '{1'b0, 8'h01, 8'h01, 8'h02, 1'b0, 1'b0};
    vecs[1] = '{1'b0, 8'hFF, 8'h01, 8'h00, 1'b1, 1'b1};
    vecs[2] = '{1'b0, 8'h80, 8'h80, 8'h00, 1'b1, 1'b1};
    vecs[3] = '{1'b0, 8'h7F, 8'h01, 8'h80, 1'b0, 1'b0};
    vecs[4] = '{1'b1, 8'h05, 8'h03, 8'h02, 1'b1, 1'b0};
    vecs[5] = '{1'b1, 8'h03, 8'h05, 8'hFE, 1'b0, 1'b0};
    vecs[6] = '{1'b1, 8'h42, 8'h42, 8'h00, 1'b1, 1'b1};
    vecs[7] = '{1'b1, 8'h00, 8'hFF, 8'h01, 1'b0, 1'b0};
    for (int i = 0; i < 8; i++) begin
      clearMem8();
      mem8[0] = 8'h0E;
      mem8[1] = vecs[i].sub ? 8'h2F : 8'h1F;
      mem8[2] = 8'hF0;
      mem8[14] = vecs[i].x;
      mem8[15] = vecs[i].y;
      applyStimulus8(1'b1);
      n = 0;
      while (!halted8 && n < 40) begin
        tick();
        n++;
      end
      checkOutput($sformatf("alu%0d_halt_cycle", i), 32'(n), 32'd16);
      checkOutput($sformatf("alu%0d_a", i), 32'(aReg8), 32'(vecs[i].expA));
      checkOutput($sformatf("alu%0d_cz", i), 32'({flagC8, flagZ8}), 32'({vecs[i].expC, vecs[i].expZ}));
    end

    // Baseline: LDA A; ADD B; SUB C; OUT; HLT with all operands 1
    clearMem8();
    mem8[0] = 8'h0A; mem8[1] = 8'h1B; mem8[2] = 8'h2C; mem8[3] = 8'hE0; mem8[4] = 8'hF0;
    mem8[10] = 8'h01; mem8[11] = 8'h01; mem8[12] = 8'h01;
    applyStimulus8(1'b1);
    ovCycle = 0; ovCount = 0; haltCycle = 0; ovVal = '0;
    for (int c = 1; c <= 34; c++) begin
      tick();
      if (outValid8) begin
        if (ovCycle == 0) ovCycle = c;
        ovCount++;
        ovVal = outReg8;
      end
      if (halted8 && haltCycle == 0) haltCycle = c;
    end
    checkOutput("base_out_cycle", 32'(ovCycle), 32'd22);
    checkOutput("base_out_count", 32'(ovCount), 32'd1);
    checkOutput("base_out_val", 32'(ovVal), 32'h01);
    checkOutput("base_halt_cycle", 32'(haltCycle), 32'd28);
    checkOutput("base_ring_frozen", 32'(ring8), 32'h08);
    checkOutput("base_pc", 32'(pc8), 32'h5);

    // Flags and conditional jumps
    clearMem8();
    mem8[0] = 8'h4F; mem8[1] = 8'h1F; mem8[2] = 8'h79;
    mem8[9] = 8'h1E; mem8[10] = 8'h63; mem8[11] = 8'hF0;
    mem8[14] = 8'h01; mem8[15] = 8'hF1;
    applyStimulus8(1'b1);
    tickN(4);
    checkOutput("ldi_a_flags", 32'({aReg8, flagC8, flagZ8}), 32'({8'h0F, 2'b00}));
    tickN(8);
    checkOutput("add_wrap_a_flags", 32'({aReg8, flagC8, flagZ8}), 32'({8'h00, 2'b11}));
    tickN(4);
    checkOutput("jz_taken_pc", 32'(pc8), 32'h9);
    tickN(8);
    checkOutput("add_nc_a_flags", 32'({aReg8, flagC8, flagZ8}), 32'({8'h01, 2'b00}));
    tickN(4);
    checkOutput("jc_not_taken_pc", 32'(pc8), 32'hB);

    // STA strobe and PC wrap: LDI 5; STA E; JMP F; NOP at F
    clearMem8();
    mem8[0] = 8'h45; mem8[1] = 8'h3E; mem8[2] = 8'h5F; mem8[14] = 8'h00;
    applyStimulus8(1'b1);
    tickN(16);
    checkOutput("jmp_pc", 32'(pc8), 32'hF);
    tickN(3);
    checkOutput("wrap_mar", 32'(bus8.mem_addr), 32'hF);
    tick();
    checkOutput("wrap_pc", 32'(pc8), 32'h0);
    checkOutput("sta_we_count", 32'(weCount), 32'd1);
    checkOutput("sta_we_edge", 32'(weEdge), 32'd11);
    checkOutput("sta_addr_data", 32'({weAddr, weData}), 32'({4'hE, 8'h05}));
    checkOutput("sta_mem", 32'(mem8[14]), 32'h05);

    // run gating
    clearMem8();
    mem8[0] = 8'h47;
    applyStimulus8(1'b0);
    bad = 0;
    for (int i = 0; i < 10; i++) begin
      tick();
      if (ring8 !== 6'b000001 || bus8.mem_addr !== 4'h0) bad++;
    end
    checkOutput("run_low_stall", 32'(bad), 32'd0);
    run8 = 1'b1;
    tick();
    checkOutput("run_high_t2", 32'(ring8), 32'h02);
    tick();
    checkOutput("run_high_t3", 32'(ring8), 32'h04);
    run8 = 1'b0;
    tickN(4);
    checkOutput("run_drop_complete", 32'({ring8, aReg8}), 32'({6'h01, 8'h07}));
    tickN(5);
    checkOutput("run_drop_stall", 32'({ring8, pc8, bus8.mem_addr}), 32'({6'h01, 4'h1, 4'h0}));

    // Asynchronous CLR mid-instruction: during STA T5 and ADD T5
    for (int k = 0; k < 2; k++) begin
      clearMem8();
      mem8[0] = 8'h4A; mem8[1] = 8'h3E; mem8[2] = 8'h1F; mem8[15] = 8'h03;
      applyStimulus8(1'b1);
      tickN(k == 0 ? 10 : 16);
      checkOutput($sformatf("abort%0d_pre_ring", k), 32'(ring8), 32'h10);
      checkOutput($sformatf("abort%0d_pre_we", k), 32'(bus8.mem_we), 32'(k == 0));
      #2;
      clr8 = 1'b1;
      #1;
      checkOutput($sformatf("abort%0d_ring", k), 32'(ring8), 32'h01);
      checkOutput($sformatf("abort%0d_regs", k), 32'({pc8, aReg8, bus8.mem_addr, outReg8}), 32'h0);
      checkOutput($sformatf("abort%0d_bits", k),
                  32'({bus8.mem_we, flagC8, flagZ8, halted8, outValid8}), 32'h0);
      @(negedge clk);
      clr8 = 1'b0;
      cyc = 0;
      tickN(2);
      checkOutput($sformatf("abort%0d_restart", k), 32'({pc8, bus8.mem_addr}), 32'({4'h1, 4'h0}));
    end

    // Randomized programs against the ISA-level model
    for (int r = 0; r < 4; r++) begin
      for (int i = 0; i < 16; i++) begin
        op = 4'($urandom_range(0, 15));
        if (op == 4'hF && $urandom_range(0, 3) != 0) op = 4'h4;
        mem8[i] = {op, 4'($urandom_range(0, 15))};
        mMem[i] = mem8[i];
      end
      mPc = '0; mA = '0; mOut = '0; mC = 1'b0; mZ = 1'b0; mHalt = 1'b0;
      applyStimulus8(1'b1);
      for (int k = 0; k < 30; k++) begin
        modelStep();
        tickN(6);
        checkOutput($sformatf("rand%0d_instr%0d", r, k),
                    32'({halted8, flagC8, flagZ8, pc8, aReg8, outReg8}),
                    32'({mHalt, mC, mZ, mPc, mA, mOut}));
      end
      bad = 0;
      for (int i = 0; i < 16; i++) if (mem8[i] !== mMem[i]) bad++;
      checkOutput($sformatf("rand%0d_mem", r), 32'(bad), 32'd0);
    end

    // Wide configuration: LDA 0x80; ADD 0x81; OUT; HLT
    clr8 = 1'b1;
    mem12[0] = 12'h080; mem12[1] = 12'h181; mem12[2] = 12'hE00; mem12[3] = 12'hF00;
    mem12[128] = 12'hFFF; mem12[129] = 12'h001;
    run12 = 1'b1;
    @(negedge clk);
    clr12 = 1'b0;
    cyc = 0;
    ovCycle = 0; haltCycle = 0;
    for (int c = 1; c <= 30; c++) begin
      tick();
      if (outValid12 && ovCycle == 0) ovCycle = c;
      if (halted12 && haltCycle == 0) haltCycle = c;
    end
    checkOutput("w12_out_cycle", 32'(ovCycle), 32'd16);
    checkOutput("w12_halt_cycle", 32'(haltCycle), 32'd22);
    checkOutput("w12_out_a", 32'({outReg12, aReg12}), 32'h0);
    checkOutput("w12_flags", 32'({flagC12, flagZ12}), 32'h3);
    checkOutput("w12_ring_pc", 32'({ring12, pc12}), 32'({6'h08, 8'h04}));

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
